// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared state encoding and defaults for the key debouncer
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  // 20 ms filter at 50 MHz, expressed as cycles minus one
  localparam int unsigned CNT_MAX_50MHZ_20MS = 999_999;

  function automatic int unsigned cnt_width(input int unsigned cnt_max);
    return (cnt_max < 1) ? 1 : $clog2(cnt_max + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous single-bit pin
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic system_clk,
  input  logic system_reset,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - debounces a raw key pin into level, press/release pulses and a toggling LED
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned CNT_MAX    = CNT_MAX_50MHZ_20MS,
  parameter logic        KEY_ACTIVE = 1'b0
) (
  input  logic system_clk,
  input  logic system_reset,
  input  logic key_0,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic led_0
);

  localparam int unsigned    CW       = cnt_width(CNT_MAX);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_MAX);

  logic key_sync;
  logic act;

  // Synchronizer idles at the released level so reset never looks like a press
  sync_2ff #(
    .RESET_VAL(~KEY_ACTIVE)
  ) u_sync (
    .system_clk  (system_clk),
    .system_reset(system_reset),
    .async_i     (key_0),
    .sync_o      (key_sync)
  );

  assign act = (key_sync == KEY_ACTIVE);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          led_q, led_d;

  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      led_q     <= led_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    led_d     = led_q;
    case (state_q)
      IDLE: begin
        if (act) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!act) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
          led_d   = ~led_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!act) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (act) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign led_0       = led_q;

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Receiving end of the push-button path: takes the raw, bouncing, asynchronous key pin and turns it into clean, registered events.
- Produces a debounced key level, one-cycle press and release pulses, and an LED that toggles on every accepted press.
- Sits between the board key pin and any downstream flip-flop/LED logic, replacing direct sampling of key_0.

Parameters:
- CNT_MAX, 999_999, filter length in cycles minus one (20 ms at 50 MHz); the bench overrides it to 4.
- KEY_ACTIVE, 1'b0, pin level that means "pressed" (board keys are active-low).

Ports:
- system_clk  input  1  single system clock, rising-edge.
- system_reset  input  1  asynchronous, active-high reset.
- key_0  input  1  raw key pin, asynchronous to system_clk, may bounce.
- key_level  output  1  debounced key state: 1 = pressed.
- key_press  output  1  one-cycle pulse when a press is accepted.
- key_release  output  1  one-cycle pulse when a release is accepted.
- led_0  output  1  toggles on each accepted press.

Behaviour:
- Clocking and reset:
  - Single clock, system_clk.
  - Reset is asynchronous and active-high on system_reset; all flops clear immediately, independent of the clock.
- Reset values:
  - Synchronizer flops = ~KEY_ACTIVE.
  - State = IDLE, counter = 0.
  - key_level = 0, key_press = 0, key_release = 0, led_0 = 0.
- Synchronizer:
  - Two flops on key_0.
  - act = (sync2 == KEY_ACTIVE).
- Counter width = $clog2(CNT_MAX+1); the counter never wraps.
- FSM states:
  - IDLE (stable released): if act, go to PRESS_WAIT with cnt = 0.
  - PRESS_WAIT:
    - If !act, go to IDLE with cnt = 0; no pulse.
    - Else if cnt == CNT_MAX, go to HELD: key_press = 1, key_level <= 1, led_0 <= ~led_0.
    - Else cnt++.
  - HELD (stable pressed): if !act, go to RELEASE_WAIT with cnt = 0.
  - RELEASE_WAIT:
    - If act, go back to HELD with cnt = 0; no pulse.
    - Else if cnt == CNT_MAX, go to IDLE: key_release = 1, key_level <= 0.
    - Else cnt++.
- Latency:
  - A clean key transition first sampled by sync1 at edge E gives key_press (or key_release) high from edge E+CNT_MAX+3, for exactly one cycle.
  - key_level and led_0 change on that same edge.
- Pulses:
  - key_press and key_release are registered and never high simultaneously.
  - Each is at most one cycle wide per accepted event.
- Bounce handling:
  - Any reversal of act during a *_WAIT state restarts filtering from the stable state; no event is emitted.
  - Acceptance requires act to hold for CNT_MAX+1 consecutive FSM samples.
- Long press: HELD persists indefinitely with no repeated pulses.
- Reset mid-operation: an asserted system_reset in any state returns all outputs to reset values at once. A held key after reset release is re-filtered and produces a fresh press.
- KEY_ACTIVE = 1 inverts only the act comparison; output polarities are unchanged.

Decomposition:
- Shared package:
  - FSM state encoding as localparams: IDLE = 2'd0, PRESS_WAIT = 2'd1, HELD = 2'd2, RELEASE_WAIT = 2'd3.
  - The default CNT_MAX for 50 MHz / 20 ms.
- One sub-module: sync_2ff.
  - Parameterised reset value.
  - Same clock and reset ports as key_debounce.
  - Reused for any other asynchronous pin.

Test Plan (CNT_MAX = 4, 20 ns clock, KEY_ACTIVE = 0):
- Reset: system_reset = 1 with key_0 = 0 -> all outputs 0 immediately, without waiting for an edge; they stay 0 for 5 cycles after release of reset, provided key_0 = 1.
- Clean press: key_0 1->0, first sampled at edge E -> key_press = 1 for exactly the cycle after edge E+7; key_level = 1 and led_0 = 1 from the same edge.
- Glitch: key_0 low for 3 cycles, then high -> no key_press; led_0 and key_level are unchanged.
- Bounce then stable: key_0 toggles every cycle for 6 cycles, then holds low -> exactly one key_press, 7 edges after the last toggle is sampled; led_0 toggles once.
- Release and second press: hold low for 20 cycles, then release -> one key_release pulse and key_level = 0. A second clean press then returns led_0 to 0.
- Reset mid-filter: assert system_reset while in PRESS_WAIT with cnt = 2 and key_0 held low -> outputs clear immediately. After deassertion, key_press arrives 7 edges after the first post-reset sampling.
- Random soak: key_0 = {$random}%2 every 20 ns for 10k cycles -> count of key_press minus key_release is 0 or 1; key_press and key_release are never simultaneous; led_0 parity equals key_press count mod 2.
